instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch sequencer for the Salamander-4 core; drives the program counter (5-bit default).
//  Reads the instruction ROM at pc_val and presents each word to the decoder over a valid/ready handshake.
//  Pulses pc_inc once per fetched word. Stops after the top address (PC wrap) or on a HALT opcode.
// PARAMETERS
//  ADDR_W    5     width of PC value / ROM address
//  INSTR_W   8     instruction word width; opcode = instr[INSTR_W-1 -: 4]
//  HALT_OPC  4'hF  opcode that ends fetching; used only when IFETCH_HALT_EN is defined
// PORTS
//  clk             in   1        clock; all logic on posedge
//  rst             in   1        synchronous, active-high reset
//  start           in   1        begin fetching; sampled only in IDLE
//  pc_val          in   ADDR_W   current PC value
//  pc_max_reached  in   1        sticky PC wrap flag
//  pc_inc          out  1        one-cycle PC increment strobe
//  mem_addr        out  ADDR_W   ROM address; combinational copy of pc_val
//  mem_rd_en       out  1        ROM read strobe; rdata is valid the cycle after
//  mem_rdata       in   INSTR_W  ROM read data
//  instr           out  INSTR_W  fetched instruction, registered
//  instr_valid     out  1        instr holds a word not yet accepted
//  instr_ready     in   1        decoder accepts when valid & ready at posedge
//  busy            out  1        high in ISSUE/WAIT/PRESENT
//  done            out  1        sticky end-of-program flag
// BEHAVIOUR
//  - Reset: state=IDLE; pc_inc, mem_rd_en, instr_valid, busy and done = 0; instr = 0.
//  - rst wins over every other input in the same cycle.
//  - Reset mid-operation drops instr_valid and any pending pc_inc. The PC block is reset separately.
//  - States: IDLE, ISSUE, WAIT, PRESENT, DONE.
//  - IDLE: start=1 -> ISSUE. All outputs low.
//  - ISSUE: mem_rd_en=1 for exactly one cycle, with address = pc_val; -> WAIT.
//  - WAIT: mem_rdata is valid; instr <= mem_rdata; pc_inc=1 for this cycle only; -> PRESENT.
//  - PRESENT: instr_valid=1; instr is held stable until accepted.
//  - PRESENT transitions:
//    - valid & ready & pc_max_reached -> DONE.
//    - valid & ready & halt (feature on) -> DONE.
//    - valid & ready otherwise -> ISSUE.
//    - !ready -> stay in PRESENT.
//  - The pc_max_reached check uses its value during PRESENT. The PC wrap from the WAIT-cycle pc_inc
//    is already visible then, so the word at MAX address is the last word presented.
//  - DONE: done=1, busy=0, no further pc_inc or mem_rd_en. start is ignored; only rst leaves DONE.
//  - Latency: start high at edge N gives mem_rd_en in N+1, pc_inc in N+2, instr_valid in N+3.
//  - Throughput: 3 cycles/word with instr_ready held high.
//  - Exactly one pc_inc per presented word; never more than one ROM read outstanding.
//  - instr_valid never drops without acceptance, except on rst.
//  - start while busy is ignored.
// CONFIGURATION
//  - IFETCH_HALT_EN defined: a word whose opcode == HALT_OPC is still presented.
//    On its acceptance -> DONE (pc_inc was already issued for it).
//  - IFETCH_HALT_EN undefined: HALT_OPC is ignored; only pc_max_reached ends fetching.
// TESTING
//  - Reset/idle: rst=1 for 2 cycles, start=0 -> all outputs 0 and no mem_rd_en for 10 cycles.
//  - Basic fetch: ROM[0]=8'h12, start pulse, ready=1 -> mem_rd_en@N+1, pc_inc@N+2, instr=8'h12 valid@N+3.
//  - Backpressure: ready=0 for 5 cycles in PRESENT -> instr stable, single pc_inc, no new mem_rd_en.
//  - Full sweep: ROM[i]=i, ready=1 -> 32 words 0..31 in order, 32 pc_inc, done=1 after word 31, then idle.
//  - Halt (IFETCH_HALT_EN): ROM[3]=8'hF0 -> words 0..3 presented, done=1, PC=4, no 5th mem_rd_en.
//    Without the macro -> all 32 words are fetched.
//  - Reset mid-PRESENT: rst=1 while instr_valid=1 -> next cycle instr_valid=0, state IDLE.
//    A new start fetches again normally.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: issues one ROM read per word, presents it over valid/ready, strobes pc_inc.
// Optional HALT-opcode stop is enabled by defining IFETCH_HALT_EN.
module instr_fetch #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned INSTR_W  = 8,
   parameter logic [3:0]  HALT_OPC = 4'hF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  pc_val,
   input  logic               pc_max_reached,
   output logic               pc_inc,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_rd_en,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic               busy,
   output logic               done
);

   localparam int unsigned OPC_W = 4;

`ifdef IFETCH_HALT_EN
   localparam logic HALT_EN = 1'b1;
`else
   localparam logic HALT_EN = 1'b0;
`endif

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE   = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_PRESENT = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]         state_q, state_d;
   logic [INSTR_W-1:0] instr_q;
   logic               pc_inc_q, mem_rd_en_q, instr_valid_q, busy_q, done_q;
   logic               is_halt;

   assign is_halt  = HALT_EN && (instr_q[INSTR_W-1 -: OPC_W] == HALT_OPC);
   assign mem_addr = pc_val;

   // next-state logic; the PC wrap from the WAIT-cycle pc_inc is already visible in PRESENT
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_ISSUE;
         S_ISSUE:   state_d = S_WAIT;
         S_WAIT:    state_d = S_PRESENT;
         S_PRESENT: begin
            if (instr_ready) begin
               if (pc_max_reached || is_halt) state_d = S_DONE;
               else                           state_d = S_ISSUE;
            end
         end
         S_DONE:    state_d = S_DONE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // outputs registered from the next state so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q       <= '0;
         pc_inc_q      <= 1'b0;
         mem_rd_en_q   <= 1'b0;
         instr_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         if (state_q == S_WAIT) instr_q <= mem_rdata;
         pc_inc_q      <= (state_d == S_WAIT);
         mem_rd_en_q   <= (state_d == S_ISSUE);
         instr_valid_q <= (state_d == S_PRESENT);
         busy_q        <= (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_PRESENT);
         done_q        <= (state_d == S_DONE);
      end
   end

   assign instr       = instr_q;
   assign pc_inc      = pc_inc_q;
   assign mem_rd_en   = mem_rd_en_q;
   assign instr_valid = instr_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: PC/ROM models, word-order scoreboard and per-cycle protocol monitor.
module tb_instr_fetch;

   localparam int unsigned AW    = 5;
   localparam int unsigned IW    = 8;
   localparam int unsigned DEPTH = 32;

`ifdef IFETCH_HALT_EN
   localparam bit HALT_ON = 1'b1;
`else
   localparam bit HALT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] pc_val;
   logic          pc_max_reached;
   logic          pc_inc;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [IW-1:0] mem_rdata;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic          instr_ready;
   logic          busy;
   logic          done;

   instr_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .pc_val         (pc_val),
      .pc_max_reached (pc_max_reached),
      .pc_inc         (pc_inc),
      .mem_addr       (mem_addr),
      .mem_rd_en      (mem_rd_en),
      .mem_rdata      (mem_rdata),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [IW-1:0] rom [DEPTH];
   logic [AW-1:0] pc_m;
   logic          wrap_m;
   logic [IW-1:0] exp_q [$];
   int            inc_cnt;
   int            acc_cnt;
   int            words_exp;
   bit            hold;
   logic [IW-1:0] prev_instr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // PC block: increments on pc_inc, sticky wrap flag when stepping past the top address
   always @(posedge clk) begin
      if (rst) begin
         pc_m   <= '0;
         wrap_m <= 1'b0;
      end else if (pc_inc) begin
         pc_m <= pc_m + AW'(1);
         if (pc_m == AW'(DEPTH - 1)) wrap_m <= 1'b1;
      end
   end
   assign pc_val         = pc_m;
   assign pc_max_reached = wrap_m;

   always @(posedge clk) if (mem_rd_en) mem_rdata <= rom[mem_addr];

   // protocol monitor; inputs change 2 time units after posedge so they are stable here
   always @(negedge clk) begin
      if (rst !== 1'b0) begin
         hold = 1'b0;
      end else begin
         check("mem_addr", 32'(mem_addr), 32'(pc_m));
         check("busy", 32'(busy), 32'(mem_rd_en | pc_inc | instr_valid));
         if (done) check("done_quiet", 32'({busy, mem_rd_en, pc_inc, instr_valid}), 32'(0));
         if (mem_rd_en) check("rd_excl", 32'(instr_valid), 32'(0));
         if (hold) check("hold", 32'({instr_valid, instr}), 32'({1'b1, prev_instr}));
         if (pc_inc) begin
            check("inc_once", 32'(inc_cnt), 32'(acc_cnt));
            inc_cnt++;
         end
         if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) check("word_extra", 32'(instr), 32'hFFFF_FFFF);
            else                   check("word", 32'(instr), 32'(exp_q.pop_front()));
            check("inc_per_word", 32'(inc_cnt), 32'(acc_cnt + 1));
            acc_cnt++;
         end
         hold       = instr_valid && !instr_ready;
         prev_instr = instr;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      start       = 1'b0;
      instr_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      exp_q.delete();
      inc_cnt = 0;
      acc_cnt = 0;
   endtask

   // expected program: consecutive words from the current PC until the top address or a HALT word
   task automatic begin_prog();
      int a;
      exp_q.delete();
      inc_cnt = 0;
      acc_cnt = 0;
      a = int'(pc_m);
      forever begin
         exp_q.push_back(rom[a]);
         if (HALT_ON && rom[a][7:4] == 4'hF) break;
         if (a == DEPTH - 1) break;
         a++;
      end
      words_exp = exp_q.size();
   endtask

   task automatic finish_prog(input bit rand_ready, input int budget, output int cycles);
      cycles = 0;
      while (!done && cycles < budget) begin
         instr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         step();
         cycles++;
      end
      check("timeout", 32'(done), 32'(1));
      check("words_left", 32'(exp_q.size()), 32'(0));
      check("inc_total", 32'(inc_cnt), 32'(words_exp));
      check("acc_total", 32'(acc_cnt), 32'(words_exp));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      int cyc;
      rst         = 1'b1;
      start       = 1'b0;
      instr_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) rom[i] = IW'($urandom);

      // reset and idle
      do_reset();
      for (int i = 0; i < 10; i++) begin
         check("idle", 32'({pc_inc, mem_rd_en, instr_valid, busy, done, instr}), 32'(0));
         step();
      end

      // basic fetch latency
      for (int i = 0; i < DEPTH; i++) rom[i] = IW'(i);
      rom[0] = 8'h12;
      do_reset();
      begin_prog();
      instr_ready = 1'b1;
      pulse_start();
      check("lat_rd", 32'({mem_rd_en, pc_inc, instr_valid}), 32'(3'b100));
      step();
      check("lat_inc", 32'({mem_rd_en, pc_inc, instr_valid}), 32'(3'b010));
      step();
      check("lat_valid", 32'({mem_rd_en, pc_inc, instr_valid}), 32'(3'b001));
      check("lat_instr", 32'(instr), 32'h12);
      finish_prog(1'b0, 400, cyc);

      // backpressure
      do_reset();
      begin_prog();
      pulse_start();
      cyc = 0;
      while (!instr_valid && cyc < 10) begin
         step();
         cyc++;
      end
      check("bp_valid", 32'(instr_valid), 32'(1));
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_instr", 32'({instr_valid, instr}), 32'({1'b1, 8'h12}));
         check("bp_one_inc", 32'({inc_cnt, mem_rd_en}), 32'({31'd1, 1'b0}));
      end
      finish_prog(1'b1, 1000, cyc);

      // full sweep at full throughput, then DONE ignores start
      for (int i = 0; i < DEPTH; i++) rom[i] = IW'(i);
      do_reset();
      begin_prog();
      pulse_start();
      finish_prog(1'b0, 400, cyc);
      check("sweep_words", 32'(acc_cnt), 32'(32));
      check("throughput", 32'(cyc), 32'(96));
      check("sweep_pc", 32'({wrap_m, pc_m}), 32'({1'b1, 5'd0}));
      for (int i = 0; i < 10; i++) begin
         start = i[0];
         step();
         check("done_idle", 32'({done, mem_rd_en, pc_inc}), 32'(3'b100));
      end
      start = 1'b0;

      // HALT word at address 3
      rom[3] = 8'hF0;
      do_reset();
      begin_prog();
      pulse_start();
      finish_prog(1'b0, 400, cyc);
      if (HALT_ON) check("halt_pc", 32'({acc_cnt, pc_m}), 32'({27'd4, 5'd4}));
      else         check("halt_pc", 32'({acc_cnt, pc_m}), 32'({27'd32, 5'd0}));

      // reset while a word is presented, then a normal run
      do_reset();
      begin_prog();
      pulse_start();
      cyc = 0;
      while (!instr_valid && cyc < 10) begin
         step();
         cyc++;
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid", 32'({instr_valid, busy, done, pc_inc, mem_rd_en}), 32'(0));
      do_reset();
      begin_prog();
      pulse_start();
      finish_prog(1'b1, 1000, cyc);

      // random programs under random backpressure
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < DEPTH; i++) rom[i] = IW'($urandom);
         do_reset();
         begin_prog();
         pulse_start();
         finish_prog(1'b1, 2000, cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
